// File: rtl/tb_cmd_executor_if.sv
// Command-line handshake between the scenario sequencer (master) and the executor (slave).
// args/args_valid carry one decoded line; ack is the single-cycle fetch strobe, busy marks a command in flight.
interface tb_cmd_executor_if #(
    parameter int ARGS_NB = 5
);
    string args [ARGS_NB];
    logic  args_valid;
    logic  ack;
    logic  busy;

    modport master (output args, output args_valid, input ack, input busy);
    modport slave  (input args, input args_valid, output ack, output busy);
endinterface

// File: rtl/tb_cmd_executor.sv
// Scenario command executor: SET/CHK/END_TEST ack one cycle after accept, WAIT_CLK n after n+1, WTR on edge or timeout.
// No backpressure: args_valid while busy is dropped and counted; define TB_CMD_EXEC_LOG_EN for a log line per ack.
module tb_cmd_executor #(
    parameter int ARGS_NB = 5,
    parameter int N_SIG   = 8,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    tb_cmd_executor_if.slave    cmd,
    output logic [N_SIG-1:0]    set_out,
    input  logic [N_SIG-1:0]    wait_in,
    input  logic [N_SIG-1:0]    check_in,
    output logic [15:0]         err_cnt,
    output logic [15:0]         proto_err_cnt,
    output logic                end_test_seen
);

    localparam int IDX_W = (N_SIG > 1) ? $clog2(N_SIG) : 1;

    typedef enum logic [2:0] {S_START, S_IDLE, S_WAIT_CYC, S_WAIT_SIG, S_ACK} state_e;
    typedef enum logic [2:0] {OP_SET, OP_CHK, OP_END, OP_WAIT, OP_WTR, OP_BAD} op_e;

    state_e             state, state_nxt;
    op_e                op;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0]   tmo, tmo_nxt;
    logic [IDX_W-1:0]   wsel, wsel_nxt;
    logic [N_SIG-1:0]   wait_prev;
    logic [N_SIG-1:0]   set_nxt;
    logic [31:0]        opd1, opd2;
    logic               ok1, ok2, idx_ok, extra_ok;
    logic [IDX_W-1:0]   idx;
    logic               val;
    logic               chk_mis, wtr_edge, wtr_tmo;
    logic               err_inc, proto_inc, end_nxt, busy_i;

    function automatic logic is_dec(input string s);
        logic       ok;
        logic [7:0] c;
        ok = (s.len() > 0);
        for (int k = 0; k < s.len(); k++) begin
            c = s.getc(k);
            if (c < 8'd48 || c > 8'd57) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [31:0] dec_val(input string s);
        logic [31:0] v;
        logic [7:0]  c;
        v = '0;
        for (int k = 0; k < s.len(); k++) begin
            c = s.getc(k);
            v = v * 32'd10 + {24'd0, c - 8'd48};
        end
        return v;
    endfunction

    // Tokens beyond the two operands must be blank, otherwise the line is malformed.
    always_comb begin
        opd1     = dec_val(cmd.args[1]);
        opd2     = dec_val(cmd.args[2]);
        ok1      = is_dec(cmd.args[1]);
        ok2      = is_dec(cmd.args[2]);
        idx_ok   = ok1 && (opd1 < 32'(N_SIG));
        extra_ok = 1'b1;
        for (int k = 3; k < ARGS_NB; k++) begin
            if (cmd.args[k] != "") extra_ok = 1'b0;
        end
        op = OP_BAD;
        if (!extra_ok)                        op = OP_BAD;
        else if (cmd.args[0] == "SET")        op = (idx_ok && ok2) ? OP_SET : OP_BAD;
        else if (cmd.args[0] == "CHK")        op = (idx_ok && ok2) ? OP_CHK : OP_BAD;
        else if (cmd.args[0] == "WTR")        op = (idx_ok && ok2) ? OP_WTR : OP_BAD;
        else if (cmd.args[0] == "WAIT_CLK")   op = ok1 ? OP_WAIT : OP_BAD;
        else if (cmd.args[0] == "END_TEST")   op = OP_END;
    end

    assign idx      = opd1[IDX_W-1:0];
    assign val      = opd2[0];
    assign chk_mis  = (check_in[idx] != val);
    assign cnt_inc  = cnt + CNT_W'(1);
    assign wtr_edge = wait_in[wsel] && !wait_prev[wsel];
    // A coincident edge wins over the timeout.
    assign wtr_tmo  = !wtr_edge && (tmo != '0) && (cnt_inc == tmo);

    assign busy_i   = !rst && (state == S_WAIT_CYC || state == S_WAIT_SIG || state == S_ACK);
    assign cmd.busy = busy_i;
    assign cmd.ack  = !rst && (state == S_ACK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        wsel_nxt  = wsel;
        set_nxt   = set_out;
        end_nxt   = end_test_seen;
        err_inc   = 1'b0;
        proto_inc = cmd.args_valid && busy_i;
        case (state)
            S_START: state_nxt = S_ACK;
            S_IDLE: begin
                if (cmd.args_valid) begin
                    state_nxt = S_ACK;
                    case (op)
                        OP_SET: set_nxt[idx] = val;
                        OP_CHK: err_inc = chk_mis;
                        OP_END: end_nxt = 1'b1;
                        OP_WAIT: begin
                            if (opd1 != 32'd0) begin
                                cnt_nxt   = CNT_W'(opd1);
                                state_nxt = S_WAIT_CYC;
                            end
                        end
                        OP_WTR: begin
                            cnt_nxt   = '0;
                            tmo_nxt   = CNT_W'(opd2);
                            wsel_nxt  = idx;
                            state_nxt = S_WAIT_SIG;
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            S_WAIT_CYC: begin
                if (cnt == CNT_W'(1)) state_nxt = S_ACK;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            S_WAIT_SIG: begin
                cnt_nxt = cnt_inc;
                if (wtr_edge) begin
                    state_nxt = S_ACK;
                end else if (wtr_tmo) begin
                    err_inc   = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_START;
            cnt           <= '0;
            tmo           <= '0;
            wsel          <= '0;
            wait_prev     <= '0;
            set_out       <= '0;
            err_cnt       <= '0;
            proto_err_cnt <= '0;
            end_test_seen <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            tmo           <= tmo_nxt;
            wsel          <= wsel_nxt;
            wait_prev     <= wait_in;
            set_out       <= set_nxt;
            end_test_seen <= end_nxt;
            if (err_inc && err_cnt != 16'hFFFF)         err_cnt       <= err_cnt + 16'd1;
            if (proto_inc && proto_err_cnt != 16'hFFFF) proto_err_cnt <= proto_err_cnt + 16'd1;
        end
    end

`ifdef TB_CMD_EXEC_LOG_EN
    string log_args [ARGS_NB];
    string log_reason;
    logic  log_end;

    function automatic string join_args(input string a [ARGS_NB]);
        string s;
        s = a[0];
        for (int k = 1; k < ARGS_NB; k++) begin
            if (a[k] != "") s = {s, " ", a[k]};
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            log_reason <= "";
            log_end    <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd.args_valid) begin
                for (int k = 0; k < ARGS_NB; k++) log_args[k] <= cmd.args[k];
                log_end    <= (op == OP_END);
                log_reason <= (op == OP_BAD) ? "bad opcode or operand" :
                              (op == OP_CHK && chk_mis) ? "check mismatch" : "";
            end else if (state == S_WAIT_SIG && wtr_tmo) begin
                log_reason <= "timeout";
            end
            if (state == S_ACK) begin
                $display("[%t] CMD %s -> %s", $time, join_args(log_args),
                         (log_reason == "") ? "OK" : {"ERR ", log_reason});
                if (log_end)
                    $display("[%t] SUMMARY err_cnt=%0d proto_err_cnt=%0d", $time, err_cnt, proto_err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tb_cmd_executor.sv
// Directed bench for tb_cmd_executor: stimulus pushes expected ack records, a negedge monitor checks them.
module tb_tb_cmd_executor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] set_out, wait_in, check_in;
    logic [15:0] err_cnt, proto_err_cnt;
    logic       end_test_seen;

    tb_cmd_executor_if #(.ARGS_NB(5)) cmd ();

    tb_cmd_executor #(.ARGS_NB(5), .N_SIG(8), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd),
        .set_out       (set_out),
        .wait_in       (wait_in),
        .check_in      (check_in),
        .err_cnt       (err_cnt),
        .proto_err_cnt (proto_err_cnt),
        .end_test_seen (end_test_seen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          issue;
        int          cyc;
        logic [7:0]  so;
        logic [15:0] err;
        logic [15:0] proto;
        logic        endf;
        bit          abort;
    } exp_t;

    exp_t q [$];
    int   tests = 0;
    int   fails = 0;
    bit   done = 0;
    bit   done_chk = 0;
    logic rst_d = 1'b0;
    logic ack_d = 1'b0;

    logic [7:0]  m_set;
    logic [15:0] m_err, m_proto;
    logic        m_end;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst) begin
            chk("rst_ack", {31'd0, cmd.ack}, 32'd0);
            chk("rst_busy", {31'd0, cmd.busy}, 32'd0);
            if (rst_d) begin
                chk("rst_set_out", {24'd0, set_out}, 32'd0);
                chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
                chk("rst_proto_cnt", {16'd0, proto_err_cnt}, 32'd0);
                chk("rst_end_seen", {31'd0, end_test_seen}, 32'd0);
            end
            while (q.size() > 0 && q[0].abort) void'(q.pop_front());
        end else begin
            if (q.size() > 0 && !q[0].abort && cyc > q[0].cyc) begin
                chk("ack_missing_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            exp_busy = (q.size() > 0) && (cyc > q[0].issue);
            chk("busy", {31'd0, cmd.busy}, {31'd0, exp_busy});
            if (cmd.ack) begin
                chk("ack_back_to_back", {31'd0, ack_d}, 32'd0);
                if (q.size() == 0 || q[0].abort) begin
                    chk("unexpected_ack", {31'd0, cmd.ack}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("set_out", {24'd0, set_out}, {24'd0, e.so});
                    chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.err});
                    chk("proto_err_cnt", {16'd0, proto_err_cnt}, {16'd0, e.proto});
                    chk("end_test_seen", {31'd0, end_test_seen}, {31'd0, e.endf});
                end
            end
        end
        if (done && !done_chk) begin
            chk("pending_expectations", q.size(), 32'd0);
            done_chk = 1;
        end
        rst_d = rst;
        ack_d = cmd.ack;
    end

    task automatic push(input int delay, input bit abort);
        exp_t e;
        e.issue = cyc;
        e.cyc   = cyc + delay;
        e.so    = m_set;
        e.err   = m_err;
        e.proto = m_proto;
        e.endf  = m_end;
        e.abort = abort;
        q.push_back(e);
    endtask

    task automatic send(input string a0, input string a1, input string a2);
        cmd.args[0] = a0;
        cmd.args[1] = a1;
        cmd.args[2] = a2;
        cmd.args[3] = "";
        cmd.args[4] = "";
        cmd.args_valid = 1'b1;
        @(posedge clk); #1;
        cmd.args_valid = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd.ack) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input string a0, input string a1, input string a2, input int delay);
        push(delay, 1'b0);
        send(a0, a1, a2);
        wait_ack(delay + 5);
    endtask

    task automatic start_up();
        m_set = '0; m_err = '0; m_proto = '0; m_end = 1'b0;
        rst = 1'b0;
        push(1, 1'b0);
        wait_ack(6);
    endtask

    initial begin
        rst = 1'b1;
        cmd.args_valid = 1'b0;
        for (int k = 0; k < 5; k++) cmd.args[k] = "";
        wait_in  = '0;
        check_in = '0;
        repeat (3) @(posedge clk);
        #1;
        start_up();
        idle(3);

        m_set = 8'h08;           do_cmd("SET", "3", "1", 1);
        m_set = 8'h00;           do_cmd("SET", "3", "0", 1);
        m_err = 16'd1;           do_cmd("SET", "9", "1", 1);
        m_set = 8'h20;           do_cmd("SET", "5", "1", 1);

        // WAIT_CLK 5 with a stray command two cycles in
        m_proto = 16'd1;
        push(6, 1'b0);
        send("WAIT_CLK", "5", "");
        @(posedge clk); #1;
        send("FOO", "1", "2");
        wait_ack(10);
        do_cmd("WAIT_CLK", "0", "", 1);

        // WTR 2 100, edge at T+7
        push(8, 1'b0);
        send("WTR", "2", "100");
        repeat (6) @(posedge clk);
        #1 wait_in[2] = 1'b1;
        wait_ack(20);
        wait_in = '0;

        m_err = 16'd2;           do_cmd("WTR", "2", "10", 11);

        // No-timeout WTR, edge at T+3
        push(4, 1'b0);
        send("WTR", "6", "0");
        repeat (2) @(posedge clk);
        #1 wait_in[6] = 1'b1;
        wait_ack(10);
        wait_in = '0;

        // Edge in the timeout cycle counts as an edge
        push(5, 1'b0);
        send("WTR", "1", "4");
        repeat (3) @(posedge clk);
        #1 wait_in[1] = 1'b1;
        wait_ack(10);
        wait_in = '0;

        check_in = 8'hA4;
        m_err = 16'd3;           do_cmd("CHK", "0", "1", 1);
        do_cmd("CHK", "2", "1", 1);
        do_cmd("CHK", "7", "1", 1);
        m_err = 16'd4;           do_cmd("CHK", "7", "0", 1);
        m_err = 16'd5;           do_cmd("FOO", "1", "2", 1);
        m_err = 16'd6;           do_cmd("SET", "1", "X", 1);

        // Reset in the middle of a WTR wait
        push(1000, 1'b1);
        send("WTR", "4", "0");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_up();
        idle(2);

        m_set = 8'h80;           do_cmd("SET", "7", "1", 1);
        m_end = 1'b1;            do_cmd("END_TEST", "", "", 1);
        idle(4);

        done = 1;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tb_cmd_executor.md
Name: tb_cmd_executor

Overview:
- Testbench-side command executor: the consumer/responder end of the scenario sequencer's args/args_valid/ack protocol.
- Decodes each command line (args[0] = opcode, args[1..] = decimal operands), drives or samples DUT-facing signal banks, and returns a single-cycle ack when the command completes.
- The ack is the sequencer's fetch strobe, so this block alone paces the scenario.
- Keeps error/protocol counters for end-of-test pass/fail.

Parameters:
- ARGS_NB, 5: number of string arguments per command line; must match the sequencer.
- N_SIG, 8: width of the set_out, wait_in and check_in signal banks.
- CNT_W, 32: width of the wait/timeout cycle counter.

Ports:
- clk  input  1  testbench clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- args  input  string[ARGS_NB]  command tokens; valid only in cycles where args_valid=1.
- args_valid  input  1  single-cycle strobe: new command present.
- ack  output  1  single-cycle pulse: command done, request next line.
- busy  output  1  command in progress (state != IDLE).
- set_out  output  N_SIG  register bank driven by the SET opcode.
- wait_in  input  N_SIG  event inputs watched by the WTR opcode.
- check_in  input  N_SIG  values compared by the CHK opcode.
- err_cnt  output  16  saturating count of check fails, timeouts, bad operands and unknown opcodes.
- proto_err_cnt  output  16  saturating count of args_valid received while busy.
- end_test_seen  output  1  sticky; set on the END_TEST opcode.

Behaviour:
Reset:
- While rst=1: ack=0, busy=0, set_out=0, err_cnt=0, proto_err_cnt=0, end_test_seen=0, state=START.
- A reset mid-command aborts the command with no ack and no counter update.

Start-up:
- In the first cycle with rst=0, state=START.
- Next edge: ack=1 for one cycle, the sequencer's initial fetch; state -> IDLE.

Opcode processing (args_valid=1 sampled in IDLE at edge T):
- Operands are parsed as unsigned decimal.
- Immediate opcodes pulse ack in cycle T+1.
- SET i v: set_out[i] <= v[0] at T+1; immediate.
- CHK i v: if check_in[i] (sampled at T) != v[0], err_cnt++; immediate.
- END_TEST: end_test_seen <= 1; immediate.
- Unknown opcode, or index i >= N_SIG: err_cnt++, no side effect; immediate.
- WAIT_CLK n: state WAIT_CYC, counter loaded with n.
  - Ack in cycle T+1+n.
  - n=0 behaves as immediate.
- WTR i t: state WAIT_SIG.
  - wait_prev is a free-running register of wait_in.
  - A rising edge is wait_in[i]=1 and wait_prev[i]=0 at edge E, with E >= T+1; ack in cycle E+1.
  - Counter increments each cycle in WAIT_SIG.
  - If t != 0 and counter reaches t with no edge: err_cnt++, ack next cycle (timeout still acks so the scenario continues).
  - t=0 means no timeout.
  - An edge and the timeout in the same cycle count as an edge, with no error.

FSM transitions:
- START -> IDLE.
- IDLE -> (immediate: ACK) | WAIT_CYC | WAIT_SIG.
- WAIT_CYC / WAIT_SIG -> ACK.
- ACK pulses ack and returns to IDLE.
- ack is never high for two consecutive cycles.

Protocol and counter rules:
- args_valid while busy=1 (including the ACK cycle): proto_err_cnt++; the command is dropped.
- Counters saturate at 16'hFFFF.
- busy=1 from T+1 until the ack cycle, inclusive.

Optional Feature:
- TB_CMD_EXEC_LOG_EN defined: $display "[%t] CMD <args> -> OK|ERR <reason>" at every ack, plus a summary of err_cnt and proto_err_cnt when END_TEST is acked.
- Not defined: no $display; counters and outputs are identical.

Test Plan:
- Release rst at cycle 0 -> exactly one ack pulse at cycle 1, busy=0, set_out=0.
- SET 3 1 at T=10 -> set_out=8'h08 and ack in cycle 11; then SET 3 0 -> set_out=0; SET 9 1 -> err_cnt=1, set_out unchanged.
- WAIT_CLK 5 at T=20 -> ack at cycle 26, busy=1 for cycles 21..26; WAIT_CLK 0 -> ack at T+1.
- WTR 2 100, with wait_in[2] rising at T+7 -> ack at T+8, err_cnt unchanged; WTR 2 10 with no edge -> ack after 10 cycles, err_cnt +1.
- CHK 0 1 with check_in[0]=0 -> err_cnt +1, ack at T+1; FOO 1 2 -> err_cnt +1; args_valid during WAIT_CLK 5 -> proto_err_cnt=1, command dropped.
- Assert rst during WTR wait -> no ack, state reset; after release, one start-up ack; END_TEST -> end_test_seen=1, ack at T+1.
